// File: rtl/lte_dl_ant_pwr_meas.sv
`default_nettype none
// ============================================================================
// Module   : lte_dl_ant_pwr_meas
// Purpose  : Per-antenna downlink power meter. Taps the 8-antenna TDM IQ
//            stream downstream of the DL TDL AGC and computes I^2+Q^2 for
//            every valid sample. The result is accumulated into one
//            accumulator per antenna slot. On each frame header the scaled,
//            saturated window power of every antenna is snapshotted into
//            result registers for software readback.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_245       in   1   processing clock
//   asy_rst       in   1   asynchronous active-high reset
//   i_fram_hd     in   1   frame header; same-cycle sample is antenna slot 0
//   i_data        in  32   [31:16] signed I, [15:0] signed Q
//   i_data_valid  in   1   sample qualifier
//   i_ant8_sel    in   1   1 = 8-antenna TDM, 0 = 2-antenna TDM
//   i_rd_ant      in   3   antenna index for result readback
//   o_pwr         out 32   registered window power of antenna i_rd_ant
//   o_pwr_upd     out  1   one-cycle pulse when result registers refresh
//   o_pwr_vld     out  1   at least one complete window is held
//   o_win_nsamp   out 16   valid samples counted in the last window
// ============================================================================
module lte_dl_ant_pwr_meas #(
    parameter int PWR_SHIFT = 8,
    parameter int ACC_W     = 48
) (
    input  logic        clk_245,
    input  logic        asy_rst,
    input  logic        i_fram_hd,
    input  logic [31:0] i_data,
    input  logic        i_data_valid,
    input  logic        i_ant8_sel,
    input  logic [2:0]  i_rd_ant,
    output logic [31:0] o_pwr,
    output logic        o_pwr_upd,
    output logic        o_pwr_vld,
    output logic [15:0] o_win_nsamp
);

    localparam int          N_ANT     = 8;
    localparam int          PAD_W     = ACC_W - 32;
    localparam logic [2:0]  LAST_SLOT = 3'd7;
    localparam logic [15:0] NSAMP_MAX = 16'hFFFF;

    // ------------------------------------------------------------------------
    // Antenna slot counter. slot_q holds the slot of the *next* sample; the
    // header overrides it so the header sample is always slot 0.
    // ------------------------------------------------------------------------
    logic [2:0] slot_q;
    logic [2:0] slot_d;
    logic [2:0] w_slot;

    always_comb begin
        w_slot = i_fram_hd ? 3'd0 : slot_q;
        slot_d = w_slot + 3'd1;
        if (i_ant8_sel) begin
            if (w_slot == LAST_SLOT) begin
                slot_d = 3'd0;
            end
        end else begin
            // Any slot >= 1 returns to 0; this also recovers cleanly when
            // the mode drops to 2-antenna in the middle of a window.
            if (w_slot != 3'd0) begin
                slot_d = 3'd0;
            end
        end
    end

    always_ff @(posedge clk_245 or posedge asy_rst) begin
        if (asy_rst) begin
            slot_q <= 3'd0;
        end else begin
            slot_q <= slot_d;
        end
    end

    // ------------------------------------------------------------------------
    // S1: input capture. Slot, valid and header travel with the data.
    // ------------------------------------------------------------------------
    logic signed [15:0] s1_i_q;
    logic signed [15:0] s1_q_q;
    logic               s1_vld_q;
    logic               s1_hd_q;
    logic [2:0]         s1_slot_q;

    always_ff @(posedge clk_245 or posedge asy_rst) begin
        if (asy_rst) begin
            s1_i_q    <= '0;
            s1_q_q    <= '0;
            s1_vld_q  <= 1'b0;
            s1_hd_q   <= 1'b0;
            s1_slot_q <= 3'd0;
        end else begin
            s1_i_q    <= i_data[31:16];
            s1_q_q    <= i_data[15:0];
            s1_vld_q  <= i_data_valid;
            s1_hd_q   <= i_fram_hd;
            s1_slot_q <= w_slot;
        end
    end

    // ------------------------------------------------------------------------
    // S2: signed squares. The largest square is (-32768)^2 = 2^30, so 31
    // unsigned bits hold it exactly. The squares are registered twice so
    // the multipliers can use both their internal and output registers.
    // ------------------------------------------------------------------------
    logic [30:0] w_isq;
    logic [30:0] w_qsq;

    assign w_isq = 31'(s1_i_q * s1_i_q);
    assign w_qsq = 31'(s1_q_q * s1_q_q);

    logic [30:0] s2a_isq_q;
    logic [30:0] s2a_qsq_q;
    logic        s2a_vld_q;
    logic        s2a_hd_q;
    logic [2:0]  s2a_slot_q;
    logic [30:0] s2b_isq_q;
    logic [30:0] s2b_qsq_q;
    logic        s2b_vld_q;
    logic        s2b_hd_q;
    logic [2:0]  s2b_slot_q;

    always_ff @(posedge clk_245 or posedge asy_rst) begin
        if (asy_rst) begin
            s2a_isq_q  <= '0;
            s2a_qsq_q  <= '0;
            s2a_vld_q  <= 1'b0;
            s2a_hd_q   <= 1'b0;
            s2a_slot_q <= 3'd0;
            s2b_isq_q  <= '0;
            s2b_qsq_q  <= '0;
            s2b_vld_q  <= 1'b0;
            s2b_hd_q   <= 1'b0;
            s2b_slot_q <= 3'd0;
        end else begin
            s2a_isq_q  <= w_isq;
            s2a_qsq_q  <= w_qsq;
            s2a_vld_q  <= s1_vld_q;
            s2a_hd_q   <= s1_hd_q;
            s2a_slot_q <= s1_slot_q;
            s2b_isq_q  <= s2a_isq_q;
            s2b_qsq_q  <= s2a_qsq_q;
            s2b_vld_q  <= s2a_vld_q;
            s2b_hd_q   <= s2a_hd_q;
            s2b_slot_q <= s2a_slot_q;
        end
    end

    // ------------------------------------------------------------------------
    // S3: instantaneous power I^2 + Q^2, at most 2^31.
    // ------------------------------------------------------------------------
    logic [31:0] s3_pwr_q;
    logic        s3_vld_q;
    logic        s3_hd_q;
    logic [2:0]  s3_slot_q;

    always_ff @(posedge clk_245 or posedge asy_rst) begin
        if (asy_rst) begin
            s3_pwr_q  <= '0;
            s3_vld_q  <= 1'b0;
            s3_hd_q   <= 1'b0;
            s3_slot_q <= 3'd0;
        end else begin
            s3_pwr_q  <= {1'b0, s2b_isq_q} + {1'b0, s2b_qsq_q};
            s3_vld_q  <= s2b_vld_q;
            s3_hd_q   <= s2b_hd_q;
            s3_slot_q <= s2b_slot_q;
        end
    end

    // ------------------------------------------------------------------------
    // S4: per-antenna accumulate and snapshot.
    // ------------------------------------------------------------------------
    logic [31:0] w_res [N_ANT];

    for (genvar k = 0; k < N_ANT; k++) begin : g_ant
        logic [ACC_W-1:0] acc_q;
        logic [31:0]      res_q;
        logic [ACC_W:0]   w_sum;
        logic [ACC_W-1:0] w_shr;
        logic             w_hit;

        assign w_hit = s3_vld_q && (s3_slot_q == 3'(k));
        assign w_sum = {1'b0, acc_q} + {{(PAD_W + 1){1'b0}}, s3_pwr_q};
        assign w_shr = acc_q >> PWR_SHIFT;

        always_ff @(posedge clk_245 or posedge asy_rst) begin
            if (asy_rst) begin
                acc_q <= '0;
                res_q <= '0;
            end else if (s3_hd_q) begin
                // The snapshot sees every sample up to the one before the
                // header; the header sample (always slot 0) opens the new
                // window, so only antenna 0 can be hit here.
                res_q <= (|w_shr[ACC_W-1:32]) ? 32'hFFFF_FFFF : w_shr[31:0];
                acc_q <= w_hit ? {{PAD_W{1'b0}}, s3_pwr_q} : '0;
            end else if (w_hit) begin
                acc_q <= w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
            end
        end

        assign w_res[k] = res_q;
    end

    // ------------------------------------------------------------------------
    // Window sample counter, status flags and readback register.
    // ------------------------------------------------------------------------
    logic [15:0] nsamp_q;
    logic [15:0] win_nsamp_q;
    logic        hdr_seen_q;
    logic        pwr_vld_q;
    logic        pwr_upd_q;
    logic [31:0] pwr_q;

    always_ff @(posedge clk_245 or posedge asy_rst) begin
        if (asy_rst) begin
            nsamp_q     <= '0;
            win_nsamp_q <= '0;
            hdr_seen_q  <= 1'b0;
            pwr_vld_q   <= 1'b0;
            pwr_upd_q   <= 1'b0;
            pwr_q       <= '0;
        end else begin
            pwr_upd_q <= s3_hd_q;
            pwr_q     <= w_res[i_rd_ant];
            if (s3_hd_q) begin
                win_nsamp_q <= nsamp_q;
                nsamp_q     <= {15'd0, s3_vld_q};
                hdr_seen_q  <= 1'b1;
                // The window before the first header is partial, so the
                // results only become trustworthy from the second header.
                if (hdr_seen_q) begin
                    pwr_vld_q <= 1'b1;
                end
            end else if (s3_vld_q && (nsamp_q != NSAMP_MAX)) begin
                nsamp_q <= nsamp_q + 16'd1;
            end
        end
    end

    assign o_pwr       = pwr_q;
    assign o_pwr_upd   = pwr_upd_q;
    assign o_pwr_vld   = pwr_vld_q;
    assign o_win_nsamp = win_nsamp_q;

endmodule

`default_nettype wire

// File: tb/tb_lte_dl_ant_pwr_meas.sv
`default_nettype none
// ============================================================================
// Module   : tb_lte_dl_ant_pwr_meas
// Purpose  : Directed self-checking bench for lte_dl_ant_pwr_meas. A
//            behavioural model tracks per-antenna window energy as stimulus
//            is driven. Each header pushes its expected snapshot, tagged
//            with the cycle it must appear, onto a scoreboard queue. The
//            entry is popped and compared when that cycle arrives.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lte_dl_ant_pwr_meas;

    localparam int SHIFT = 8;
    localparam int AW    = 48;

    logic        clk_245;
    logic        asy_rst;
    logic        i_fram_hd;
    logic [31:0] i_data;
    logic        i_data_valid;
    logic        i_ant8_sel;
    logic [2:0]  i_rd_ant;
    logic [31:0] o_pwr;
    logic        o_pwr_upd;
    logic        o_pwr_vld;
    logic [15:0] o_win_nsamp;

    lte_dl_ant_pwr_meas #(
        .PWR_SHIFT (SHIFT),
        .ACC_W     (AW)
    ) u_dut (
        .clk_245      (clk_245),
        .asy_rst      (asy_rst),
        .i_fram_hd    (i_fram_hd),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .i_ant8_sel   (i_ant8_sel),
        .i_rd_ant     (i_rd_ant),
        .o_pwr        (o_pwr),
        .o_pwr_upd    (o_pwr_upd),
        .o_pwr_vld    (o_pwr_vld),
        .o_win_nsamp  (o_win_nsamp)
    );

    initial clk_245 = 1'b0;
    always #5 clk_245 = ~clk_245;

    typedef struct packed {
        logic [7:0][31:0] res;
        logic [15:0]      nsamp;
        logic             vld;
        logic [31:0]      due;
    } snap_t;

    snap_t sb_q[$];

    localparam longint unsigned ACC_MAX = (64'd1 << AW) - 64'd1;
    localparam logic [31:0] TONE = 32'h0100_0000;
    localparam logic [31:0] SATD = 32'h8000_8000;

    longint unsigned  m_acc [8];
    int               m_cnt;
    bit               m_seen;
    logic [2:0]       m_next_slot;
    logic [7:0][31:0] m_res;
    logic [15:0]      m_nsamp;
    logic             m_vld;
    logic [31:0]      m_opwr;
    int               cyc;
    int               n_vec;
    int               n_err;

    function automatic logic [31:0] sat32(input longint unsigned x);
        return (x > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : x[31:0];
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 8; k++) m_acc[k] = 0;
        m_cnt       = 0;
        m_seen      = 1'b0;
        m_next_slot = 3'd0;
        m_res       = '0;
        m_nsamp     = '0;
        m_vld       = 1'b0;
        m_opwr      = '0;
        sb_q.delete();
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive, update the model, check all outputs
    // on the falling edge, then advance past the next rising edge.
    task automatic tick(input logic hd, input logic [31:0] d, input logic v, input logic [2:0] rd);
        logic [2:0]        slot;
        longint            ii;
        longint            qq;
        longint unsigned   pw;
        longint unsigned   sum;
        logic signed [15:0] si;
        logic signed [15:0] sq;
        snap_t             e;
        logic              exp_upd;

        i_fram_hd    = hd;
        i_data       = d;
        i_data_valid = v;
        i_rd_ant     = rd;

        if (asy_rst) begin
            model_clear();
        end else begin
            slot = hd ? 3'd0 : m_next_slot;
            if (i_ant8_sel) m_next_slot = (slot == 3'd7) ? 3'd0 : slot + 3'd1;
            else            m_next_slot = (slot >= 3'd1) ? 3'd0 : slot + 3'd1;
            si = d[31:16];
            sq = d[15:0];
            ii = longint'(si);
            qq = longint'(sq);
            pw = longint'(ii * ii + qq * qq);
            if (hd) begin
                for (int k = 0; k < 8; k++) e.res[k] = sat32(m_acc[k] >> SHIFT);
                e.nsamp = 16'(m_cnt);
                e.vld   = m_seen;
                e.due   = 32'(cyc + 5);
                sb_q.push_back(e);
                m_seen = 1'b1;
                for (int k = 0; k < 8; k++) m_acc[k] = 0;
                if (v) m_acc[0] = pw;
                m_cnt = v ? 1 : 0;
            end else if (v) begin
                sum = m_acc[slot] + pw;
                m_acc[slot] = (sum > ACC_MAX) ? ACC_MAX : sum;
                m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
            end
        end

        @(negedge clk_245);
        exp_upd = 1'b0;
        if (sb_q.size() > 0 && sb_q[0].due == 32'(cyc)) begin
            e       = sb_q.pop_front();
            m_res   = e.res;
            m_nsamp = e.nsamp;
            m_vld   = m_vld | e.vld;
            exp_upd = 1'b1;
        end
        chk("upd",       {31'd0, o_pwr_upd}, {31'd0, exp_upd});
        chk("win_nsamp", {16'd0, o_win_nsamp}, {16'd0, m_nsamp});
        chk("pwr_vld",   {31'd0, o_pwr_vld}, {31'd0, m_vld});
        chk("pwr",       o_pwr, m_opwr);
        m_opwr = m_res[rd];

        @(posedge clk_245);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'd0, 1'b0, 3'(cyc));
    endtask

    task automatic read_ant(input string tag, input logic [2:0] ant, input logic [31:0] exp);
        tick(1'b0, 32'd0, 1'b0, ant);
        chk(tag, o_pwr, exp);
    endtask

    initial begin
        logic [15:0] a;
        n_vec        = 0;
        n_err        = 0;
        cyc          = 0;
        asy_rst      = 1'b1;
        i_fram_hd    = 1'b0;
        i_data       = 32'd0;
        i_data_valid = 1'b0;
        i_ant8_sel   = 1'b1;
        i_rd_ant     = 3'd0;
        model_clear();
        @(posedge clk_245);
        #1;

        // Reset state
        idle(3);
        asy_rst = 1'b0;
        chk("rst_pwr",   o_pwr, 32'd0);
        chk("rst_upd",   {31'd0, o_pwr_upd}, 32'd0);
        chk("rst_vld",   {31'd0, o_pwr_vld}, 32'd0);
        chk("rst_nsamp", {16'd0, o_win_nsamp}, 32'd0);

        // Constant tone, 8 antennas, 800-cycle windows
        for (int w = 0; w < 3; w++)
            for (int i = 0; i < 800; i++) tick(i == 0, TONE, 1'b1, 3'(i));
        tick(1'b1, TONE, 1'b1, 3'd0);
        idle(6);
        chk("tone_nsamp", {16'd0, o_win_nsamp}, 32'd800);
        chk("tone_vld",   {31'd0, o_pwr_vld}, 32'd1);
        read_ant("tone_ant0", 3'd0, 32'h0000_6400);
        read_ant("tone_ant7", 3'd7, 32'h0000_6400);

        // Per-antenna separation, 64-cycle windows
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 64; i++) begin
                a = 16'(16 * ((i % 8) + 1));
                tick(i == 0, {a, a}, 1'b1, 3'(i));
            end
        tick(1'b1, 32'd0, 1'b0, 3'd0);
        idle(6);
        read_ant("sep_ant0", 3'd0, 32'd16);
        read_ant("sep_ant3", 3'd3, 32'd256);
        read_ant("sep_ant7", 3'd7, 32'd1024);
        chk("sep_nsamp", {16'd0, o_win_nsamp}, 32'd64);

        // Saturation of the 32-bit result, then a zero-data window
        for (int i = 0; i < 4200; i++) tick(i == 0, SATD, 1'b1, 3'(i));
        tick(1'b1, 32'd0, 1'b1, 3'd0);
        for (int i = 0; i < 62; i++) tick(1'b0, 32'd0, 1'b1, 3'(i));
        read_ant("sat_ant5", 3'd5, 32'hFFFF_FFFF);
        read_ant("sat_ant0", 3'd0, 32'hFFFF_FFFF);
        tick(1'b1, 32'd0, 1'b0, 3'd0);
        idle(6);
        read_ant("zero_ant5", 3'd5, 32'd0);

        // 2-antenna mode
        i_ant8_sel = 1'b0;
        for (int i = 0; i < 100; i++) tick(i == 0, TONE, 1'b1, 3'(i));
        tick(1'b1, 32'd0, 1'b0, 3'd0);
        idle(6);
        read_ant("ant2_ant0", 3'd0, 32'd12800);
        read_ant("ant2_ant1", 3'd1, 32'd12800);
        read_ant("ant2_ant4", 3'd4, 32'd0);

        // Mode drops to 2-antenna while at slot 5
        i_ant8_sel = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) i_ant8_sel = 1'b0;
            tick(i == 0, TONE, 1'b1, 3'(i));
        end
        tick(1'b1, 32'd0, 1'b0, 3'd0);
        idle(6);
        read_ant("sw_ant5", 3'd5, 32'd256);
        read_ant("sw_ant0", 3'd0, 32'd2048);
        read_ant("sw_ant6", 3'd6, 32'd0);

        // Valid gaps, header on an invalid cycle, exact t+5 update
        i_ant8_sel = 1'b1;
        for (int i = 0; i < 101; i++) tick(i == 0, TONE, (i % 2) == 1, 3'(i));
        tick(1'b1, TONE, 1'b0, 3'd0);
        idle(3);
        chk("gap_upd_t4", {31'd0, o_pwr_upd}, 32'd0);
        idle(1);
        chk("gap_upd_t5", {31'd0, o_pwr_upd}, 32'd1);
        chk("gap_nsamp",  {16'd0, o_win_nsamp}, 32'd50);
        idle(1);
        chk("gap_upd_t6", {31'd0, o_pwr_upd}, 32'd0);

        // Reset in the middle of a window
        for (int i = 0; i < 30; i++) tick(i == 0, TONE, 1'b1, 3'(i));
        asy_rst = 1'b1;
        idle(3);
        asy_rst = 1'b0;
        chk("mrst_pwr",   o_pwr, 32'd0);
        chk("mrst_vld",   {31'd0, o_pwr_vld}, 32'd0);
        chk("mrst_nsamp", {16'd0, o_win_nsamp}, 32'd0);
        for (int i = 0; i < 40; i++) tick(i == 0, TONE, 1'b1, 3'(i));
        chk("mrst_vld_hdr1", {31'd0, o_pwr_vld}, 32'd0);
        tick(1'b1, 32'd0, 1'b0, 3'd0);
        idle(6);
        chk("mrst_vld_hdr2", {31'd0, o_pwr_vld}, 32'd1);
        chk("mrst_nsamp2",   {16'd0, o_win_nsamp}, 32'd40);

        // Back-to-back headers
        tick(1'b1, TONE, 1'b1, 3'd0);
        tick(1'b1, TONE, 1'b1, 3'd1);
        tick(1'b1, 32'd0, 1'b0, 3'd2);
        idle(8);
        chk("b2b_nsamp", {16'd0, o_win_nsamp}, 32'd1);
        read_ant("b2b_ant0", 3'd0, 32'd256);

        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
